reduction_sequencer: RTL and testbench



---
 rtl/reduction_pkg.sv | 25 ++
 rtl/reduce_chunk.sv | 15 +
 rtl/reduction_sequencer.sv | 131 +++++++++++++
 tb/tb_reduction_sequencer.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/reduction_pkg.sv
// Shared types and constants for the chunked AND/OR/XOR reduction sequencer.
package reduction_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } red_state_e;

  typedef struct packed {
    logic and_r;
    logic or_r;
    logic xor_r;
  } red_result_t;

  localparam logic AND_INIT = 1'b1;
  localparam logic OR_INIT  = 1'b0;
  localparam logic XOR_INIT = 1'b0;

  // Chunk counter width; a single-chunk word still needs a 1-bit counter.
  function automatic int cnt_width(input int nchunk);
    return (nchunk > 1) ? $clog2(nchunk) : 1;
  endfunction

endpackage

// File: rtl/reduce_chunk.sv
// Narrow combinational reduction unit shared by all chunks of a word.
module reduce_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  output logic             and_a,
  output logic             or_a,
  output logic             xor_a
);

  assign and_a = &a;
  assign or_a  = |a;
  assign xor_a = ^a;

endmodule

// File: rtl/reduction_sequencer.sv
// Reduces a WIDTH-bit word CHUNK bits per cycle through one reduce_chunk,
// with valid/ready handshakes on both the word input and the result output.
module reduction_sequencer
  import reduction_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             and_r,
  output logic             or_r,
  output logic             xor_r,
  output logic             busy
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = cnt_width(NCHUNK);

  generate
    if (CHUNK <= 0 || WIDTH <= 0 || (WIDTH % CHUNK) != 0) begin : g_bad_params
      $error("reduction_sequencer: WIDTH must be a positive multiple of CHUNK");
    end
  endgenerate

  red_state_e       state_q;
  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] shreg_d;
  logic [CW-1:0]    cnt_q;
  red_result_t      acc_q;
  red_result_t      acc_d;
  red_result_t      res_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             busy_q;
  logic             c_and;
  logic             c_or;
  logic             c_xor;
  logic             last_chunk;

  reduce_chunk #(.CHUNK(CHUNK)) u_reduce (
    .a     (shreg_q[CHUNK-1:0]),
    .and_a (c_and),
    .or_a  (c_or),
    .xor_a (c_xor)
  );

  // A single-chunk word has nothing left to shift in.
  generate
    if (NCHUNK > 1) begin : g_shift
      assign shreg_d = {{CHUNK{1'b0}}, shreg_q[WIDTH-1:CHUNK]};
    end else begin : g_noshift
      assign shreg_d = '0;
    end
  endgenerate

  always_comb begin
    acc_d       = acc_q;
    acc_d.and_r = acc_q.and_r & c_and;
    acc_d.or_r  = acc_q.or_r | c_or;
    acc_d.xor_r = acc_q.xor_r ^ c_xor;
  end

  assign last_chunk = (cnt_q == CW'(NCHUNK - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      cnt_q       <= '0;
      acc_q       <= '0;
      res_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            shreg_q     <= in_data;
            acc_q.and_r <= AND_INIT;
            acc_q.or_r  <= OR_INIT;
            acc_q.xor_r <= XOR_INIT;
            cnt_q       <= '0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= BUSY;
          end
        end
        BUSY: begin
          acc_q   <= acc_d;
          shreg_q <= shreg_d;
          if (last_chunk) begin
            res_q       <= acc_d;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign and_r     = res_q.and_r;
  assign or_r      = res_q.or_r;
  assign xor_r     = res_q.xor_r;

endmodule

// File: tb/tb_reduction_sequencer.sv
// Three sequencer configurations (32/4, 32/32, 8/2) driven in lockstep and
// checked against a whole-word reduction model.
module tb_reduction_sequencer;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_data;
  logic        out_ready;

  logic a_in_ready, a_out_valid, a_and, a_or, a_xor, a_busy;
  logic b_in_ready, b_out_valid, b_and, b_or, b_xor, b_busy;
  logic c_in_ready, c_out_valid, c_and, c_or, c_xor, c_busy;

  int n_tests;
  int n_fail;

  reduction_sequencer #(.WIDTH(32), .CHUNK(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_data(in_data), .out_valid(a_out_valid), .out_ready(out_ready),
    .and_r(a_and), .or_r(a_or), .xor_r(a_xor), .busy(a_busy)
  );

  reduction_sequencer #(.WIDTH(32), .CHUNK(32)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_data(in_data), .out_valid(b_out_valid), .out_ready(out_ready),
    .and_r(b_and), .or_r(b_or), .xor_r(b_xor), .busy(b_busy)
  );

  reduction_sequencer #(.WIDTH(8), .CHUNK(2)) dut_c (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(c_in_ready),
    .in_data(in_data[7:0]), .out_valid(c_out_valid), .out_ready(out_ready),
    .and_r(c_and), .or_r(c_or), .xor_r(c_xor), .busy(c_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [2:0]  exp;      // {and, or, xor} for the 32-bit word
    int          stall;
    bit          scramble;
  } vec_t;

  vec_t tbl[6];

  // Whole-word reduction of the low w bits: {all ones, any one, parity}.
  function automatic logic [2:0] ref_red(input logic [31:0] d, input int w);
    logic [31:0] m;
    logic [31:0] dm;
    m  = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    dm = d & m;
    return {dm == m, dm != 32'd0, ^dm};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called just after a posedge with all DUTs idle.
  task automatic xact(input logic [31:0] d, input logic [2:0] exp_a,
                      input int stall, input bit scramble);
    int cyc, la, lb, lc;
    logic [2:0] eb, ec;
    eb = ref_red(d, 32);
    ec = ref_red(d, 8);
    chk("in_ready_idle_a", {31'd0, a_in_ready}, 32'd1);
    chk("in_ready_idle_b", {31'd0, b_in_ready}, 32'd1);
    chk("in_ready_idle_c", {31'd0, c_in_ready}, 32'd1);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk); #1;
    in_valid = scramble;
    in_data  = ~d;
    chk("busy_after_accept", {29'd0, a_busy, b_busy, c_busy}, 32'd7);
    chk("out_valid_after_accept", {29'd0, a_out_valid, b_out_valid, c_out_valid}, 32'd0);
    la = -1; lb = -1; lc = -1; cyc = 0;
    while ((la < 0 || lb < 0 || lc < 0) && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (la < 0 && a_out_valid) la = cyc;
      if (lb < 0 && b_out_valid) lb = cyc;
      if (lc < 0 && c_out_valid) lc = cyc;
      if (la < 0) chk("in_ready_low_busy", {31'd0, a_in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    chk("latency_32_4", la, 32'd8);
    chk("latency_32_32", lb, 32'd1);
    chk("latency_8_2", lc, 32'd4);
    for (int s = 0; s < stall; s++) begin
      chk("stall_valid", {31'd0, a_out_valid}, 32'd1);
      chk("stall_result", {29'd0, a_and, a_or, a_xor}, {29'd0, exp_a});
      @(posedge clk); #1;
    end
    chk("result_32_4", {29'd0, a_and, a_or, a_xor}, {29'd0, exp_a});
    chk("result_32_32", {29'd0, b_and, b_or, b_xor}, {29'd0, eb});
    chk("result_8_2", {29'd0, c_and, c_or, c_xor}, {29'd0, ec});
    chk("in_ready_done", {31'd0, a_in_ready}, 32'd0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("out_valid_after_hs", {29'd0, a_out_valid, b_out_valid, c_out_valid}, 32'd0);
    chk("in_ready_after_hs", {29'd0, a_in_ready, b_in_ready, c_in_ready}, 32'd7);
    chk("busy_after_hs", {31'd0, a_busy}, 32'd0);
    chk("result_held_idle", {29'd0, a_and, a_or, a_xor}, {29'd0, exp_a});
    $display("[TB] word %08h -> 32/4 %03b lat %0d, 32/32 lat %0d, 8/2 lat %0d", d,
             {a_and, a_or, a_xor}, la, lb, lc);
  endtask

  initial begin
    logic [31:0] d;
    n_tests   = 0;
    n_fail    = 0;
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    in_data   = 32'd0;
    out_ready = 1'b0;

    tbl[0] = '{32'h0000_0000, 3'b000, 0, 1'b0};
    tbl[1] = '{32'hFFFF_FFFF, 3'b110, 0, 1'b0};
    tbl[2] = '{32'h0000_0001, 3'b011, 1, 1'b0};
    tbl[3] = '{32'h8000_0007, 3'b010, 0, 1'b0};
    tbl[4] = '{32'h0000_0003, 3'b010, 5, 1'b1};
    tbl[5] = '{32'h0000_00B1, 3'b010, 2, 1'b1};

    #3 rst_n = 1'b0;
    #1;
    chk("reset_in_ready", {29'd0, a_in_ready, b_in_ready, c_in_ready}, 32'd7);
    chk("reset_out_valid", {29'd0, a_out_valid, b_out_valid, c_out_valid}, 32'd0);
    chk("reset_results", {29'd0, a_and, a_or, a_xor}, 32'd0);
    chk("reset_busy", {29'd0, a_busy, b_busy, c_busy}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++)
      xact(tbl[i].data, tbl[i].exp, tbl[i].stall, tbl[i].scramble);

    // Reset with a word in flight: 32/4 is mid-BUSY, 32/32 is sitting in DONE.
    in_valid = 1'b1;
    in_data  = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {29'd0, a_out_valid, b_out_valid, c_out_valid}, 32'd0);
    chk("midrst_in_ready", {29'd0, a_in_ready, b_in_ready, c_in_ready}, 32'd7);
    chk("midrst_busy", {29'd0, a_busy, b_busy, c_busy}, 32'd0);
    chk("midrst_results_a", {29'd0, a_and, a_or, a_xor}, 32'd0);
    chk("midrst_results_b", {29'd0, b_and, b_or, b_xor}, 32'd0);
    repeat (2) @(posedge clk);
    #1 chk("midrst_no_output", {29'd0, a_out_valid, b_out_valid, c_out_valid}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    xact(32'h0000_0010, 3'b011, 0, 1'b0);

    for (int i = 0; i < 24; i++) begin
      d = $urandom;
      case ($urandom_range(0, 3))
        0: d = 32'hFFFF_FFFF ^ (32'd1 << $urandom_range(0, 31));
        1: d = 32'd1 << $urandom_range(0, 31);
        default: ;
      endcase
      xact(d, ref_red(d, 32), int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
